// File: rtl/login_pkg.sv
// login_pkg: shared types and helpers for the login sequencer.
//   state_e   - sequencer states; the encoding doubles as the 7-segment status code.
//   cnt_width - width of the shared cycle counter for the chosen timing parameters.
package login_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEntry   = 3'd1,
    StCheck   = 3'd2,
    StSession = 3'd3,
    StDenied  = 3'd4,
    StLockout = 3'd5
  } state_e;

  // Bits needed to hold the largest interval any state times with the shared counter.
  function automatic int unsigned cnt_width(input int unsigned entry_timeout,
                                            input int unsigned lockout_cycles,
                                            input int unsigned deny_hold,
                                            input int unsigned check_wait);
    int unsigned m;
    m = entry_timeout;
    if (lockout_cycles > m) m = lockout_cycles;
    if (deny_hold > m) m = deny_hold;
    if (check_wait > m) m = check_wait;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/login_timer.sv
// login_timer: loadable down-counter shared by the login sequencer's timed states.
//   clk, rst  - clock and asynchronous active-high reset
//   clr       - force the count to zero (idle, no expiry pending)
//   load      - load load_val; takes priority over clr
//   load_val  - interval in cycles; expire rises in the load_val-th cycle after the load
//   expire    - one-cycle pulse while the count passes through one
module login_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Zero is the parked value, so the pulse fires once per load.
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/login_ctrl.sv
// login_ctrl: session/login sequencer in front of the user_id block.
//   Inputs : clk, rst (async, active-high), key_load/key_digit (raw digit key),
//            logout, session_done, user_allow (verdict from user_id).
//   Outputs: uid_load/uid_digit (one-cycle load to user_id), uid_clear, digit_cnt,
//            attempts_left, session_active, denied, locked, timeout_evt, status.
// Every output comes straight from a flop; most are computed from the next state.
module login_ctrl
  import login_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned CHECK_LAT      = 2,
  parameter int unsigned ENTRY_TIMEOUT  = 500,
  parameter int unsigned DENY_HOLD      = 50,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic [3:0] key_digit,
  input  logic       logout,
  input  logic       session_done,
  input  logic       user_allow,
  output logic       uid_load,
  output logic [3:0] uid_digit,
  output logic       uid_clear,
  output logic [2:0] digit_cnt,
  output logic [1:0] attempts_left,
  output logic       session_active,
  output logic       denied,
  output logic       locked,
  output logic       timeout_evt,
  output logic [2:0] status
);

  localparam int unsigned CntW = cnt_width(ENTRY_TIMEOUT, LOCKOUT_CYCLES, DENY_HOLD,
                                           CHECK_LAT + 1);
  localparam logic [2:0] DigitsC = 3'(DIGITS);
  localparam logic [1:0] MaxAttC = 2'(MAX_ATTEMPTS);

  state_e state_q, state_d;
  logic key_q, press;
  logic uid_load_q, uid_load_d;
  logic [3:0] uid_digit_q, uid_digit_d;
  logic uid_clear_q, uid_clear_d;
  logic [2:0] digit_cnt_q, digit_cnt_d;
  logic [1:0] attempts_q, attempts_d;
  logic session_q, session_d;
  logic denied_q, denied_d;
  logic locked_q, locked_d;
  logic timeout_q, timeout_d;
  logic tmr_load, tmr_clr, tmr_expire;
  logic [CntW-1:0] tmr_val;

  assign press = key_load & ~key_q;

  login_timer #(
    .W(CntW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d     = state_q;
    uid_load_d  = 1'b0;
    uid_digit_d = uid_digit_q;
    digit_cnt_d = digit_cnt_q;
    attempts_d  = attempts_q;
    timeout_d   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      StIdle: begin
        if (press) begin
          uid_load_d  = 1'b1;
          uid_digit_d = key_digit;
          digit_cnt_d = 3'd1;
          tmr_load    = 1'b1;
          if (DIGITS == 1) begin
            state_d = StCheck;
            tmr_val = CntW'(CHECK_LAT + 1);
          end else begin
            state_d = StEntry;
            tmr_val = CntW'(ENTRY_TIMEOUT);
          end
        end
      end
      StEntry: begin
        // Logout aborts outright; a press beats a timeout landing on the same edge.
        if (logout) begin
          state_d     = StIdle;
          digit_cnt_d = 3'd0;
        end else if (press) begin
          uid_load_d  = 1'b1;
          uid_digit_d = key_digit;
          digit_cnt_d = (digit_cnt_q < DigitsC) ? digit_cnt_q + 3'd1 : DigitsC;
          tmr_load    = 1'b1;
          if (digit_cnt_d == DigitsC) begin
            state_d = StCheck;
            tmr_val = CntW'(CHECK_LAT + 1);
          end else begin
            tmr_val = CntW'(ENTRY_TIMEOUT);
          end
        end else if (tmr_expire) begin
          state_d     = StIdle;
          digit_cnt_d = 3'd0;
          timeout_d   = 1'b1;
        end
      end
      StCheck: begin
        // Expiry lands CHECK_LAT cycles after the final uid_load pulse.
        if (tmr_expire) begin
          if (user_allow) begin
            attempts_d = MaxAttC;
            state_d    = StSession;
          end else if (attempts_q <= 2'd1) begin
            attempts_d = 2'd0;
            state_d    = StLockout;
            tmr_load   = 1'b1;
            tmr_val    = CntW'(LOCKOUT_CYCLES);
          end else begin
            attempts_d = attempts_q - 2'd1;
            state_d    = StDenied;
            tmr_load   = 1'b1;
            tmr_val    = CntW'(DENY_HOLD);
          end
        end
      end
      StSession: begin
        if (logout || session_done) begin
          state_d     = StIdle;
          digit_cnt_d = 3'd0;
        end
      end
      StDenied: begin
        if (tmr_expire) begin
          state_d     = StIdle;
          digit_cnt_d = 3'd0;
        end
      end
      StLockout: begin
        if (tmr_expire) begin
          state_d     = StIdle;
          digit_cnt_d = 3'd0;
          attempts_d  = MaxAttC;
        end
      end
      default: begin
        state_d     = StIdle;
        digit_cnt_d = 3'd0;
      end
    endcase

    // Any state change not loading a new interval parks the counter.
    tmr_clr     = (state_d != state_q);
    uid_clear_d = (state_d == StIdle) || (state_d == StDenied) || (state_d == StLockout);
    session_d   = (state_d == StSession);
    denied_d    = (state_d == StDenied);
    locked_d    = (state_d == StLockout);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      key_q       <= 1'b0;
      uid_load_q  <= 1'b0;
      uid_digit_q <= 4'd0;
      uid_clear_q <= 1'b1;
      digit_cnt_q <= 3'd0;
      attempts_q  <= MaxAttC;
      session_q   <= 1'b0;
      denied_q    <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_load;
      uid_load_q  <= uid_load_d;
      uid_digit_q <= uid_digit_d;
      uid_clear_q <= uid_clear_d;
      digit_cnt_q <= digit_cnt_d;
      attempts_q  <= attempts_d;
      session_q   <= session_d;
      denied_q    <= denied_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign uid_load       = uid_load_q;
  assign uid_digit      = uid_digit_q;
  assign uid_clear      = uid_clear_q;
  assign digit_cnt      = digit_cnt_q;
  assign attempts_left  = attempts_q;
  assign session_active = session_q;
  assign denied         = denied_q;
  assign locked         = locked_q;
  assign timeout_evt    = timeout_q;
  assign status         = state_q;

endmodule

// File: tb/tb_login_ctrl.sv
// Self-checking bench for login_ctrl with default parameters.
module tb_login_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_load = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       logout = 1'b0;
  logic       session_done = 1'b0;
  logic       user_allow = 1'b0;
  logic       uid_load;
  logic [3:0] uid_digit;
  logic       uid_clear;
  logic [2:0] digit_cnt;
  logic [1:0] attempts_left;
  logic       session_active;
  logic       denied;
  logic       locked;
  logic       timeout_evt;
  logic [2:0] status;

  always #5 clk = ~clk;

  login_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .key_load      (key_load),
    .key_digit     (key_digit),
    .logout        (logout),
    .session_done  (session_done),
    .user_allow    (user_allow),
    .uid_load      (uid_load),
    .uid_digit     (uid_digit),
    .uid_clear     (uid_clear),
    .digit_cnt     (digit_cnt),
    .attempts_left (attempts_left),
    .session_active(session_active),
    .denied        (denied),
    .locked        (locked),
    .timeout_evt   (timeout_evt),
    .status        (status)
  );

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int tevt_cnt = 0;

  always @(posedge clk) begin
    if (uid_load) load_cnt <= load_cnt + 1;
    if (timeout_evt) tevt_cnt <= tevt_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       key;
    logic [3:0] dig;
    logic       lo;
    logic       sd;
    logic       e_load;
    logic [3:0] e_dig;
    logic [2:0] e_cnt;
    logic [2:0] e_st;
    logic       e_sess;
    logic       e_clr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic key, input logic [3:0] dig, input logic lo, input logic sd,
                     input logic e_load, input logic [3:0] e_dig, input logic [2:0] e_cnt,
                     input logic [2:0] e_st, input logic e_sess, input logic e_clr);
    vec_t v;
    v.key = key; v.dig = dig; v.lo = lo; v.sd = sd;
    v.e_load = e_load; v.e_dig = e_dig; v.e_cnt = e_cnt;
    v.e_st = e_st; v.e_sess = e_sess; v.e_clr = e_clr;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    for (int i = 0; i < hold; i++) begin
      key_load = 1'b1;
      key_digit = d;
      step();
    end
    key_load = 1'b0;
    step();
  endtask

  task automatic enter4(input logic [15:0] id);
    for (int i = 0; i < 4; i++) press(id[15-4*i -: 4], 3);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_uid_load"}, uid_load, 0);
    chk({tag, "_uid_digit"}, uid_digit, 0);
    chk({tag, "_uid_clear"}, uid_clear, 1);
    chk({tag, "_digit_cnt"}, digit_cnt, 0);
    chk({tag, "_attempts"}, attempts_left, 3);
    chk({tag, "_session"}, session_active, 0);
    chk({tag, "_denied"}, denied, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout_evt, 0);
    chk({tag, "_status"}, status, 0);
  endtask

  // One rejected attempt that leaves attempts > 0: 50 cycles of denied, then IDLE.
  task automatic fail_once(input int exp_att);
    int n;
    user_allow = 1'b0;
    enter4(16'h1234);
    chk("fail_attempts", attempts_left, exp_att);
    chk("fail_status", status, 4);
    chk("fail_uid_clear", uid_clear, 1);
    n = 0;
    while (denied && n < 200) begin
      step();
      n++;
    end
    chk("deny_hold_cycles", n, 50);
    chk("after_deny_status", status, 0);
    chk("after_deny_digit_cnt", digit_cnt, 0);
  endtask

  initial begin
    int n, l0, t0;

    // Reset values with rst held over clock edges.
    repeat (2) step();
    chk_reset("reset");
    rst = 1'b0;

    // Good login A,B,C,1 held 3 cycles each, then session exit and logout in ENTRY.
    //  key dig  lo sd   load dig  cnt st sess clr
    add(1, 4'hA, 0, 0,   1, 4'hA, 1, 1, 0, 0);
    add(1, 4'hA, 0, 0,   0, 4'h0, 1, 1, 0, 0);
    add(1, 4'hA, 0, 0,   0, 4'h0, 1, 1, 0, 0);
    add(0, 4'h0, 0, 0,   0, 4'h0, 1, 1, 0, 0);
    add(1, 4'hB, 0, 0,   1, 4'hB, 2, 1, 0, 0);
    add(1, 4'hB, 0, 0,   0, 4'h0, 2, 1, 0, 0);
    add(1, 4'hB, 0, 0,   0, 4'h0, 2, 1, 0, 0);
    add(0, 4'h0, 0, 0,   0, 4'h0, 2, 1, 0, 0);
    add(1, 4'hC, 0, 0,   1, 4'hC, 3, 1, 0, 0);
    add(1, 4'hC, 0, 0,   0, 4'h0, 3, 1, 0, 0);
    add(1, 4'hC, 0, 0,   0, 4'h0, 3, 1, 0, 0);
    add(0, 4'h0, 0, 0,   0, 4'h0, 3, 1, 0, 0);
    add(1, 4'h1, 0, 0,   1, 4'h1, 4, 2, 0, 0);
    add(1, 4'h1, 0, 0,   0, 4'h0, 4, 2, 0, 0);
    add(1, 4'h1, 0, 0,   0, 4'h0, 4, 2, 0, 0);
    add(0, 4'h0, 0, 0,   0, 4'h0, 4, 3, 1, 0);
    add(0, 4'h0, 0, 0,   0, 4'h0, 4, 3, 1, 0);
    add(1, 4'h5, 0, 0,   0, 4'h0, 4, 3, 1, 0);
    add(0, 4'h0, 1, 1,   0, 4'h0, 0, 0, 0, 1);
    add(0, 4'h0, 0, 0,   0, 4'h0, 0, 0, 0, 1);
    add(1, 4'h7, 0, 0,   1, 4'h7, 1, 1, 0, 0);
    add(0, 4'h0, 1, 0,   0, 4'h0, 0, 0, 0, 1);
    add(0, 4'h0, 0, 0,   0, 4'h0, 0, 0, 0, 1);

    user_allow = 1'b1;
    foreach (vq[i]) begin
      key_load = vq[i].key;
      key_digit = vq[i].dig;
      logout = vq[i].lo;
      session_done = vq[i].sd;
      step();
      chk($sformatf("vec%0d_uid_load", i), uid_load, vq[i].e_load);
      if (vq[i].e_load) chk($sformatf("vec%0d_uid_digit", i), uid_digit, vq[i].e_dig);
      chk($sformatf("vec%0d_digit_cnt", i), digit_cnt, vq[i].e_cnt);
      chk($sformatf("vec%0d_status", i), status, vq[i].e_st);
      chk($sformatf("vec%0d_session", i), session_active, vq[i].e_sess);
      chk($sformatf("vec%0d_uid_clear", i), uid_clear, vq[i].e_clr);
      chk($sformatf("vec%0d_attempts", i), attempts_left, 3);
    end
    logout = 1'b0;
    session_done = 1'b0;

    // Three rejections: two denials, then lockout that swallows presses.
    fail_once(2);
    fail_once(1);
    enter4(16'h1234);
    chk("lock_attempts", attempts_left, 0);
    chk("lock_locked", locked, 1);
    chk("lock_status", status, 5);
    chk("lock_denied", denied, 0);
    l0 = load_cnt;
    n = 0;
    while (locked && n < 2000) begin
      key_load = (n < 900) && ((n % 8) < 3);
      key_digit = 4'h9;
      step();
      n++;
    end
    key_load = 1'b0;
    chk("lockout_cycles", n, 1000);
    chk("lockout_loads_ignored", load_cnt - l0, 0);
    chk("after_lock_attempts", attempts_left, 3);
    chk("after_lock_status", status, 0);
    chk("after_lock_digit_cnt", digit_cnt, 0);
    step();

    // Entry timeout after two digits.
    t0 = tevt_cnt;
    press(4'h2, 3);
    press(4'h3, 3);
    chk("to_digit_cnt_before", digit_cnt, 2);
    n = 0;
    while (status != 3'd0 && n < 1000) begin
      step();
      n++;
    end
    chk("to_cycles", n, 497);
    chk("to_evt", timeout_evt, 1);
    chk("to_digit_cnt", digit_cnt, 0);
    chk("to_uid_clear", uid_clear, 1);
    chk("to_attempts", attempts_left, 3);
    step();
    chk("to_evt_one_cycle", timeout_evt, 0);
    chk("to_evt_count", tevt_cnt - t0, 1);

    // Key held 20 cycles gives one load; then a press on the expiry edge wins.
    l0 = load_cnt;
    press(4'h6, 20);
    chk("held_key_loads", load_cnt - l0, 1);
    chk("held_digit_cnt", digit_cnt, 1);
    repeat (479) step();
    chk("pre_expiry_status", status, 1);
    t0 = tevt_cnt;
    key_load = 1'b1;
    key_digit = 4'h8;
    step();
    chk("race_uid_load", uid_load, 1);
    chk("race_uid_digit", uid_digit, 8);
    chk("race_digit_cnt", digit_cnt, 2);
    chk("race_status", status, 1);
    chk("race_no_timeout", timeout_evt, 0);
    key_load = 1'b0;
    repeat (3) step();
    chk("race_timeout_count", tevt_cnt - t0, 0);
    logout = 1'b1;
    step();
    logout = 1'b0;
    chk("logout_entry_status", status, 0);
    chk("logout_entry_digit_cnt", digit_cnt, 0);

    // Asynchronous reset in LOCKOUT, checked before any clock edge.
    fail_once(2);
    fail_once(1);
    enter4(16'h1234);
    chk("pre_rst_locked", locked, 1);
    repeat (10) step();
    #2 rst = 1'b1;
    #1 chk_reset("rst_lockout");
    step();
    rst = 1'b0;

    // Asynchronous reset in SESSION.
    user_allow = 1'b1;
    enter4(16'hABC1);
    chk("pre_rst_session", session_active, 1);
    repeat (5) step();
    #2 rst = 1'b1;
    #1 chk_reset("rst_session");
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
